xbus_arbiter: RTL and testbench

Two-master arbiter sharing the single peripheral bus (address decoder, memory, register file, mult/div, buttons, display peripherals) between the CPU (master 0) and a secondary master such as DMA or a debug loader (master 1). Grants one transaction at a time, drives the decoder's `addr`/`sel` plus write data, waits a fixed read latency, and returns read data with a one-cycle ack. Arbitration is round-robin, with an optional lock that lets a master issue back-to-back transactions.

---
 rtl/xbus_arbiter.sv | 137 +++++++++++++
 tb/tb_xbus_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/xbus_arbiter.sv
// xbus_arbiter: two-master round-robin bus arbiter with lock, fixed read latency and registered outputs.
// Define XARB_TIMEOUT_EN to break a lock that starves the other master for TIMEOUT cycles.
`ifndef ADDR_W
`define ADDR_W 16
`endif
module xbus_arbiter #(
  parameter int ADDR_W  = `ADDR_W,
  parameter int DATA_W  = 32,
  parameter int LAT     = 1,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m0_we,
  input  logic              m1_we,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m0_lock,
  input  logic              m1_lock,
  output logic              m0_ack,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] addr,
  output logic              sel,
  output logic              we,
  output logic [DATA_W-1:0] data_to_wr,
  input  logic [DATA_W-1:0] data_to_rd,
  output logic [1:0]        grant,
  output logic              timeout_err
);
  localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, WAIT = 2'd2, ACK = 2'd3;
  localparam int CW = $clog2(LAT + 1);
  logic [1:0] state_q, state_d, grant_q;
  logic [CW-1:0] wcnt_q;
  logic own_q, rr_last_q, lock_hold_q, lock_own_q;
  logic win, start, lock_ok, lock_keep, tmo_clr;
  logic sel_q, we_q, m0_ack_q, m1_ack_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, m0_rdata_q, m1_rdata_q;
  assign start = (state_q == IDLE) && (m0_req || m1_req);
  // A held lock wins only while its owner keeps requesting; otherwise plain round-robin.
  assign win = (lock_ok && (lock_own_q ? m1_req : m0_req)) ? lock_own_q :
               (m0_req && m1_req) ? ~rr_last_q : m1_req;
  always_comb
    state_d = state_q == IDLE   ? (start ? ACCESS : IDLE) :
              state_q == ACCESS ? WAIT :
              state_q == WAIT   ? (wcnt_q == CW'(1) ? ACK : WAIT) : IDLE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= 2'b00;
      wcnt_q      <= '0;
      own_q       <= 1'b0;
      rr_last_q   <= 1'b1;
      lock_hold_q <= 1'b0;
      lock_own_q  <= 1'b0;
      sel_q       <= 1'b0;
      we_q        <= 1'b0;
      m0_ack_q    <= 1'b0;
      m1_ack_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= start;
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
      if (start) begin
        own_q     <= win;
        rr_last_q <= win;
        grant_q   <= win ? 2'b10 : 2'b01;
        addr_q    <= win ? m1_addr : m0_addr;
        we_q      <= win ? m1_we : m0_we;
        wdata_q   <= win ? m1_wdata : m0_wdata;
      end
      if (state_q == ACCESS) wcnt_q <= CW'(LAT);
      if (state_q == WAIT) begin
        wcnt_q <= wcnt_q - 1'b1;
        if (wcnt_q == CW'(1)) begin
          m0_ack_q <= ~own_q;
          m1_ack_q <= own_q;
          if (own_q) m1_rdata_q <= data_to_rd;
          else m0_rdata_q <= data_to_rd;
        end
      end
      if (state_q == ACK) begin
        grant_q     <= 2'b00;
        lock_hold_q <= (own_q ? m1_lock : m0_lock) & lock_keep;
        lock_own_q  <= own_q;
      end
      if (tmo_clr) lock_hold_q <= 1'b0;
    end
  end
`ifdef XARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt_q;
  logic tmo_q, terr_q, waiting;
  assign waiting     = lock_hold_q && (lock_own_q ? m0_req : m1_req);
  assign tmo_clr     = waiting && (tcnt_q == TW'(TIMEOUT - 1));
  assign lock_ok     = lock_hold_q && !tmo_clr;
  assign lock_keep   = ~tmo_q & ~tmo_clr;
  assign timeout_err = terr_q;
  // tmo_q remembers a broken lock until one plain round-robin arbitration has happened.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tcnt_q <= '0;
      tmo_q  <= 1'b0;
      terr_q <= 1'b0;
    end else begin
      tcnt_q <= (!lock_hold_q || tmo_clr || (start && win != lock_own_q)) ? '0 : tcnt_q + TW'(waiting);
      tmo_q  <= tmo_clr ? !start : (start ? 1'b0 : tmo_q);
      terr_q <= terr_q | tmo_clr;
    end
  end
`else
  assign tmo_clr     = 1'b0;
  assign lock_ok     = lock_hold_q;
  assign lock_keep   = 1'b1;
  assign timeout_err = 1'b0;
`endif
  assign m0_ack     = m0_ack_q;
  assign m1_ack     = m1_ack_q;
  assign m0_rdata   = m0_rdata_q;
  assign m1_rdata   = m1_rdata_q;
  assign addr       = addr_q;
  assign sel        = sel_q;
  assign we         = we_q;
  assign data_to_wr = wdata_q;
  assign grant      = grant_q;
endmodule

// File: tb/tb_xbus_arbiter.sv
// tb_xbus_arbiter: directed stimulus for xbus_arbiter, checked every cycle against a transaction-timeline model.
`timescale 1ns/1ps
module tb_xbus_arbiter;
  localparam int AW = 16, DW = 32, LAT = 1, TMO = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  logic m0_req = 0, m1_req = 0, m0_we = 0, m1_we = 0, m0_lock = 0, m1_lock = 0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0, addr;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0, data_to_rd = '0, m0_rdata, m1_rdata, data_to_wr;
  logic m0_ack, m1_ack, sel, we, timeout_err;
  logic [1:0] grant;
  int checks = 0, errors = 0;
  bit go = 0;

  always #5 clk = ~clk;

  xbus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LAT(LAT), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m1_req(m1_req), .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_we(m0_we), .m1_we(m1_we), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_lock(m0_lock), .m1_lock(m1_lock), .m0_ack(m0_ack), .m1_ack(m1_ack),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata), .addr(addr), .sel(sel), .we(we),
    .data_to_wr(data_to_wr), .data_to_rd(data_to_rd), .grant(grant), .timeout_err(timeout_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a transaction runs ph=1 (sel) .. LAT+2 (ack) cycles after its grant.
  int ph = 0, tcnt = 0;
  bit own = 0, rr_last = 1, lk_hold = 0, lk_own = 0, force_rr = 0, hit, gnow, lkh_old, lko, nonown;
  logic e_sel = 0, e_ack0 = 0, e_ack1 = 0, e_we = 0, e_err = 0;
  logic [1:0] e_grant = 0;
  logic [AW-1:0] e_addr = 0;
  logic [DW-1:0] e_wd = 0, e_rd0 = 0, e_rd1 = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      ph = 0; tcnt = 0; own = 0; rr_last = 1; lk_hold = 0; lk_own = 0; force_rr = 0;
      e_sel = 0; e_grant = 0; e_ack0 = 0; e_ack1 = 0; e_rd0 = 0; e_rd1 = 0;
      e_addr = 0; e_we = 0; e_wd = 0; e_err = 0;
    end else begin
      lkh_old = lk_hold;
      lko = lk_own;
      nonown = lk_own ? m0_req : m1_req;
      hit = 0;
`ifdef XARB_TIMEOUT_EN
      hit = lk_hold && nonown && (tcnt + 1 == TMO);
`endif
      gnow = (ph == 0) && (m0_req || m1_req);
      e_ack0 = 0;
      e_ack1 = 0;
      if (gnow) begin
        if (lk_hold && !hit && (lk_own ? m1_req : m0_req)) own = lk_own;
        else if (m0_req && m1_req) own = !rr_last;
        else own = m1_req;
        rr_last = own;
        ph = 1;
        e_grant = own ? 2'b10 : 2'b01;
        e_addr = own ? m1_addr : m0_addr;
        e_we = own ? m1_we : m0_we;
        e_wd = own ? m1_wdata : m0_wdata;
      end else if (ph == LAT + 2) begin
        ph = 0;
        e_grant = 0;
        lk_hold = (own ? m1_lock : m0_lock) && !force_rr && !hit;
        lk_own = own;
      end else if (ph > 0) begin
        if (ph == LAT + 1) begin
          if (own) begin e_ack1 = 1; e_rd1 = data_to_rd; end
          else begin e_ack0 = 1; e_rd0 = data_to_rd; end
        end
        ph++;
      end
      e_sel = gnow;
`ifdef XARB_TIMEOUT_EN
      if (!lkh_old || hit || (gnow && own != lko)) tcnt = 0;
      else if (nonown) tcnt++;
      if (hit) begin e_err = 1; lk_hold = 0; force_rr = !gnow; end
      else if (gnow) force_rr = 0;
`endif
    end
  end

  always @(negedge clk) if (go) begin
    chk("cmp_sel", sel, e_sel);
    chk("cmp_grant", grant, e_grant);
    chk("cmp_m0_ack", m0_ack, e_ack0);
    chk("cmp_m1_ack", m1_ack, e_ack1);
    chk("cmp_m0_rdata", m0_rdata, e_rd0);
    chk("cmp_m1_rdata", m1_rdata, e_rd1);
    chk("cmp_addr", addr, e_addr);
    chk("cmp_we", we, e_we);
    chk("cmp_wdata", data_to_wr, e_wd);
    chk("cmp_timeout_err", timeout_err, e_err);
  end

  task automatic wait_sel(input string name, input logic [1:0] exp_g, input logic [AW-1:0] exp_a);
    int n = 0;
    do begin @(negedge clk); n++; end while (!sel && n < 40);
    chk({name, "_sel"}, sel, 1);
    chk({name, "_grant"}, grant, exp_g);
    chk({name, "_addr"}, addr, exp_a);
  endtask

  task automatic wait_ack(input string name, input bit m);
    int n = 0;
    do begin @(negedge clk); n++; end while (!(m ? m1_ack : m0_ack) && n < 40);
    chk(name, m ? m1_ack : m0_ack, 1);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    m0_addr = 16'h100; m0_we = 1; m0_wdata = 32'h0000A0A0;
    m1_addr = 16'h200; m1_we = 0; m1_wdata = 32'h0000B1B1;
    data_to_rd = 32'h12345678;
    m0_req = 1; m1_req = 1; rst_n = 0;
    @(posedge clk);
    go = 1;
    cyc(2);
    chk("rst_sel", sel, 0);
    chk("rst_grant", grant, 0);
    chk("rst_acks", {m0_ack, m1_ack}, 0);
    chk("rst_rdata", {m0_rdata, m1_rdata}, 0);
    chk("rst_bus", {addr, we, data_to_wr}, 0);
    chk("rst_terr", timeout_err, 0);
    rst_n = 1;
    @(negedge clk);
    chk("first_c0_sel", sel, 0);
    wait_sel("first", 2'b01, 16'h100);
    chk("first_we", we, 1);
    chk("first_wdata", data_to_wr, 32'h0000A0A0);
    wait_sel("alt2", 2'b10, 16'h200);
    chk("alt2_we", we, 0);
    wait_sel("alt3", 2'b01, 16'h100);
    wait_sel("alt4", 2'b10, 16'h200);
    m0_req = 0; m1_req = 0;
    wait_ack("alt4_ack", 1);
    cyc(3);
    data_to_rd = 32'hDEADBEEF; m0_addr = 16'h010; m0_we = 0; m0_req = 1;
    @(negedge clk); chk("t2_sel_c0", sel, 0);
    @(negedge clk); chk("t2_sel_c1", sel, 1); chk("t2_addr", addr, 16'h010);
    @(negedge clk); chk("t2_ack_c2", m0_ack, 0);
    @(negedge clk); chk("t2_ack_c3", m0_ack, 1); chk("t2_rdata", m0_rdata, 32'hDEADBEEF); chk("t2_m1_ack", m1_ack, 0);
    @(posedge clk); #1; m0_req = 0;
    @(negedge clk); chk("t2_ack_c4", m0_ack, 0); chk("t2_rdata_hold", m0_rdata, 32'hDEADBEEF);
    cyc(3);
    m1_lock = 1; m0_req = 1; m1_req = 1;
    wait_sel("lock1", 2'b10, 16'h200);
    wait_sel("lock2", 2'b10, 16'h200);
    wait_sel("lock3", 2'b10, 16'h200);
    m1_lock = 0;
    wait_sel("unlock", 2'b01, 16'h010);
    m0_req = 0; m1_req = 0;
    wait_ack("unlock_ack", 0);
    cyc(3);
    data_to_rd = 32'hCAFE0001; m0_req = 1;
    @(negedge clk);
    @(negedge clk); chk("t4_sel", sel, 1);
    @(posedge clk); #1; rst_n = 0;
    @(posedge clk); #1;
    chk("t4_rst_ack", m0_ack, 0);
    chk("t4_rst_sel", sel, 0);
    chk("t4_rst_grant", grant, 0);
    rst_n = 1;
    wait_ack("t4_fresh_ack", 0);
    chk("t4_fresh_rdata", m0_rdata, 32'hCAFE0001);
    @(posedge clk); #1; m0_req = 0;
    cyc(3);
`ifdef XARB_TIMEOUT_EN
    m1_lock = 1; m0_req = 1; m1_req = 1;
    begin
      int n = 0;
      do begin @(negedge clk); n++; end while (!timeout_err && n < 200);
    end
    chk("tmo_err", timeout_err, 1);
    if (!sel) wait_sel("tmo_next", 2'b01, 16'h010);
    else chk("tmo_next_now", grant, 2'b01);
    m1_lock = 0; m0_req = 0; m1_req = 0;
    cyc(8);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
